// File: rtl/sbus_pkg.sv
// Shared definitions for the gpioemu slave bus: bus widths, initiator FSM states
// and the read/write opcode encoding used on the command port.
package sbus_pkg;

    localparam int unsigned SBUS_AW = 16;
    localparam int unsigned SBUS_DW = 32;

    localparam logic SBUS_OP_READ  = 1'b0;
    localparam logic SBUS_OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } sbus_state_e;

endpackage

// File: rtl/sbus_initiator.sv
// Host-side initiator: turns one valid/ready command into a timed srd/swr strobe access
// on the gpioemu slave bus and returns one response per command.
module sbus_initiator
    import sbus_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned SAMPLE_CYCLE  = 2
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [SBUS_AW-1:0] cmd_addr,
    input  logic [SBUS_DW-1:0] cmd_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_write,
    output logic [SBUS_DW-1:0] rsp_rdata,
    output logic               busy,
    output logic [SBUS_AW-1:0] saddress,
    output logic               srd,
    output logic               swr,
    output logic [SBUS_DW-1:0] sdata_in,
    input  logic [SBUS_DW-1:0] sdata_out
);

    localparam int unsigned   CW         = $clog2(STROBE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(STROBE_CYCLES);
    localparam logic [CW-1:0] SAMPLE_CNT = CW'(SAMPLE_CYCLE);

    generate
        if (STROBE_CYCLES < 1 || SAMPLE_CYCLE < 1 || SAMPLE_CYCLE > STROBE_CYCLES) begin : g_bad_params
            $error("sbus_initiator: need 1 <= SAMPLE_CYCLE <= STROBE_CYCLES");
        end
    endgenerate

    sbus_state_e        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [SBUS_DW-1:0] rdata_q, rdata_d;

    logic               cmd_ready_d, busy_d, srd_d, swr_d;
    logic               rsp_valid_d, rsp_write_d;
    logic [SBUS_DW-1:0] rsp_rdata_d, sdata_in_d;
    logic [SBUS_AW-1:0] saddress_d;

    // Every output is a register; the next-state logic computes their next values so
    // an async reset clears srd/swr immediately.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            rdata_q   <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            srd       <= 1'b0;
            swr       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            saddress  <= '0;
            sdata_in  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rdata_q   <= rdata_d;
            cmd_ready <= cmd_ready_d;
            busy      <= busy_d;
            srd       <= srd_d;
            swr       <= swr_d;
            rsp_valid <= rsp_valid_d;
            rsp_write <= rsp_write_d;
            rsp_rdata <= rsp_rdata_d;
            saddress  <= saddress_d;
            sdata_in  <= sdata_in_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        rdata_d     = rdata_q;
        cmd_ready_d = cmd_ready;
        busy_d      = busy;
        srd_d       = srd;
        swr_d       = swr;
        rsp_valid_d = rsp_valid;
        rsp_write_d = rsp_write;
        rsp_rdata_d = rsp_rdata;
        saddress_d  = saddress;
        sdata_in_d  = sdata_in;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d     = SETUP;
                    wr_d        = cmd_write;
                    rdata_d     = '0;
                    saddress_d  = cmd_addr;
                    sdata_in_d  = (cmd_write == SBUS_OP_WRITE) ? cmd_wdata : '0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CW'(1);
                srd_d   = (wr_q == SBUS_OP_READ);
                swr_d   = (wr_q == SBUS_OP_WRITE);
            end
            STROBE: begin
                // cnt_q is the 1-based index of the strobe cycle now closing
                if (wr_q == SBUS_OP_READ && cnt_q == SAMPLE_CNT) begin
                    rdata_d = sdata_out;
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = HOLD;
                    srd_d   = 1'b0;
                    swr_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                state_d     = RESP;
                saddress_d  = '0;
                sdata_in_d  = '0;
                rsp_valid_d = 1'b1;
                rsp_write_d = wr_q;
                rsp_rdata_d = (wr_q == SBUS_OP_WRITE) ? '0 : rdata_q;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = '0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sbus_initiator.sv
// Randomized and directed bench for sbus_initiator against a gpioemu-style slave and a
// command-level memory model; a second instance runs with SAMPLE_CYCLE=1 in lockstep.
module tb_sbus_initiator;

    localparam int unsigned STB = 2;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        cmd_valid, cmd_write, rsp_ready;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [31:0] sdata_out;

    logic        cmd_ready, rsp_valid, rsp_write, busy, srd, swr;
    logic [31:0] rsp_rdata, sdata_in;
    logic [15:0] saddress;

    logic        b_cmd_ready, b_rsp_valid, b_rsp_write, b_busy, b_srd, b_swr;
    logic [31:0] b_rsp_rdata, b_sdata_in;
    logic [15:0] b_saddress;

    always #5 clk = ~clk;

    sbus_initiator #(.STROBE_CYCLES(STB), .SAMPLE_CYCLE(2)) u_dut (
        .clk(clk), .n_reset(n_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .busy(busy), .saddress(saddress), .srd(srd), .swr(swr),
        .sdata_in(sdata_in), .sdata_out(sdata_out)
    );

    sbus_initiator #(.STROBE_CYCLES(STB), .SAMPLE_CYCLE(1)) u_dut_s1 (
        .clk(clk), .n_reset(n_reset), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(b_rsp_write),
        .rsp_rdata(b_rsp_rdata), .busy(b_busy), .saddress(b_saddress), .srd(b_srd), .swr(b_swr),
        .sdata_in(b_sdata_in), .sdata_out(sdata_out)
    );

    // Slave: 16 words decoded from saddress[7:4], written while swr is high at a clock edge.
    logic [31:0] slave_mem [16];
    logic [31:0] slave_rd;
    logic        ovr_en;
    logic [31:0] ovr_val;

    always_comb slave_rd = srd ? slave_mem[saddress[7:4]] : '0;
    assign sdata_out = ovr_en ? ovr_val : slave_rd;

    always @(posedge clk) begin
        if (n_reset && swr) slave_mem[saddress[7:4]] <= sdata_in;
    end

    logic [31:0] exp_mem [16];
    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Bus-level monitor: strobes mutually exclusive, >=2 low cycles between strobes.
    int unsigned low_run  = 99;
    logic        prev_stb = 1'b0;
    always @(negedge clk) begin
        if (!n_reset) begin
            low_run  = 99;
            prev_stb = 1'b0;
        end else begin
            chk("srd_swr_excl", {31'b0, srd & swr}, 32'd0);
            if (srd | swr) begin
                if (!prev_stb) chk("strobe_gap", {31'b0, low_run >= 2}, 32'd1);
                low_run  = 0;
                prev_stb = 1'b1;
            end else begin
                low_run++;
                prev_stb = 1'b0;
            end
        end
    end

    // Entered and left #1 after a clock edge with the initiator idle.
    task automatic run_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                           input int unsigned hold, input logic ovr);
        int unsigned cyc, first_stb, n_stb;
        logic [31:0] exp_rd0, exp_rd1;
        logic [3:0]  idx;
        idx     = addr[7:4];
        ovr_en  = ovr;
        ovr_val = 32'hAAAA0000;
        chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 16'($urandom); cmd_wdata = $urandom;
        cyc = 1; first_stb = 0; n_stb = 0;
        while (!rsp_valid && cyc < 40) begin
            if (srd | swr) begin
                if (first_stb == 0) first_stb = cyc;
                n_stb++;
                chk("strobe_kind", {31'b0, swr}, {31'b0, wr});
                if (ovr) ovr_val = (n_stb == 1) ? 32'hAAAA0000 : 32'h5555FFFF;
            end
            if (cyc <= 2 + STB) begin
                chk("saddress", {16'b0, saddress}, {16'b0, addr});
                chk("sdata_in", sdata_in, wr ? wdata : 32'd0);
                chk("busy_cmd_ready", {30'b0, busy, cmd_ready}, 32'd2);
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("rsp_latency", cyc, 3 + STB);
        if (cyc >= 40) begin
            ovr_en = 1'b0;
            return;
        end
        chk("strobe_start", first_stb, 32'd2);
        chk("strobe_len", n_stb, STB);
        exp_rd0 = wr ? 32'd0 : (ovr ? 32'h5555FFFF : exp_mem[idx]);
        exp_rd1 = wr ? 32'd0 : (ovr ? 32'hAAAA0000 : exp_mem[idx]);
        if (wr) exp_mem[idx] = wdata;
        chk("bus_idle_resp", {sdata_in[31:16] | sdata_in[15:0], saddress}, 32'd0);
        rsp_ready = 1'b0;
        for (int unsigned i = 0; i < hold; i++) begin
            chk("bp_hold", {29'b0, rsp_valid, busy, cmd_ready}, 32'd6);
            chk("bp_rdata", rsp_rdata, exp_rd0);
            chk("bp_write", {31'b0, rsp_write}, {31'b0, wr});
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rsp_write", {31'b0, rsp_write}, {31'b0, wr});
        chk("rsp_rdata", rsp_rdata, exp_rd0);
        chk("rsp_rdata_s1", b_rsp_rdata, exp_rd1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        ovr_en    = 1'b0;
        chk("back_idle", {29'b0, rsp_valid, busy, cmd_ready}, 32'd1);
    endtask

    logic [15:0] b2b_addr [3];
    int unsigned acc_t [3];
    int unsigned n_acc, n_rsp;
    logic        acc_now, any_rsp;
    logic [3:0]  ridx;

    initial begin
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = 32'h11111111 * i;
            exp_mem[i]   = 32'h11111111 * i;
        end
        slave_mem[1] = 32'h12345678;
        exp_mem[1]   = 32'h12345678;
        n_reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; rsp_ready = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; ovr_en = 1'b0; ovr_val = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {27'b0, cmd_ready, busy, rsp_valid, srd, swr}, 32'h10);
        chk("reset_data", rsp_rdata | sdata_in | {16'b0, saddress} | {31'b0, rsp_write}, 32'd0);
        n_reset = 1'b1;
        @(posedge clk); #1;

        run_cmd(1'b1, 16'h00F0, 32'hDEADBEEF, 0, 1'b0);
        run_cmd(1'b0, 16'h0010, 32'h0, 0, 1'b0);
        run_cmd(1'b0, 16'h0020, 32'h0, 0, 1'b1);
        run_cmd(1'b1, 16'h0030, 32'hCAFEF00D, 5, 1'b0);
        run_cmd(1'b0, 16'h0030, 32'h0, 5, 1'b0);

        // Back-to-back reads with cmd_valid held high and rsp_ready tied high.
        b2b_addr = '{16'h0010, 16'h00F0, 16'h0030};
        cmd_write = 1'b0; cmd_addr = b2b_addr[0]; cmd_valid = 1'b1; rsp_ready = 1'b1;
        n_acc = 0; n_rsp = 0;
        for (int unsigned c = 0; c < 60 && n_rsp < 3; c++) begin
            acc_now = cmd_valid && cmd_ready;
            if (acc_now && n_acc < 3) begin
                acc_t[n_acc] = c;
                n_acc++;
            end
            if (rsp_valid) begin
                if (n_rsp < n_acc) begin
                    ridx = b2b_addr[n_rsp][7:4];
                    chk("b2b_rdata", rsp_rdata, exp_mem[ridx]);
                    chk("b2b_rdata_s1", b_rsp_rdata, exp_mem[ridx]);
                end
                n_rsp++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                if (n_acc < 3) cmd_addr = b2b_addr[n_acc];
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        chk("b2b_count", n_rsp, 32'd3);
        chk("b2b_period0", acc_t[1] - acc_t[0], 4 + STB);
        chk("b2b_period1", acc_t[2] - acc_t[1], 4 + STB);
        chk("b2b_idle", {31'b0, cmd_ready}, 32'd1);

        // Reset in the middle of a write strobe: dropped without a response.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0050; cmd_wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_swr", {31'b0, swr}, 32'd1);
        n_reset = 1'b0;
        #1;
        chk("rst_async_ctrl", {27'b0, cmd_ready, busy, rsp_valid, srd, swr}, 32'h10);
        chk("rst_async_data", rsp_rdata | sdata_in | {16'b0, saddress} | {31'b0, rsp_write}, 32'd0);
        @(posedge clk); #1;
        n_reset = 1'b1;
        any_rsp = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            any_rsp = any_rsp | rsp_valid | busy;
        end
        chk("rst_no_rsp", {31'b0, any_rsp}, 32'd0);
        run_cmd(1'b0, 16'h0050, 32'h0, 1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            run_cmd(1'($urandom), 16'($urandom), $urandom, $urandom_range(0, 3), 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
